// File: rtl/lb_master_arb.sv
// Local-bus master with a two-port round-robin arbiter in front of it.
// Each accepted request runs one full ALE / setup / strobe / release bus cycle.
module lb_master_arb #(
   parameter int unsigned ALE_CYCLES   = 2,
   parameter int unsigned SETUP_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 255,
   parameter logic [3:0]  SPACE        = 4'h1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req0_valid,
   input  logic        i_req0_wr,
   input  logic [27:0] i_req0_addr,
   input  logic [31:0] i_req0_wdata,
   input  logic        i_req1_valid,
   input  logic        i_req1_wr,
   input  logic [27:0] i_req1_addr,
   input  logic [31:0] i_req1_wdata,
   output logic        o_req0_ready,
   output logic        o_req1_ready,
   output logic        o_req0_done,
   output logic        o_req1_done,
   output logic        o_rsp_err,
   output logic [31:0] o_rsp_rdata,
   output logic        o_lb_ale,
   output logic        o_lb_cs_n,
   output logic        o_lb_rd_wr,
   output logic [31:0] o_lb_data_out,
   output logic        o_lb_data_oe,
   input  logic [31:0] i_lb_data_in,
   input  logic        i_lb_ack_n,
   output logic        o_busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ALE, S_AHOLD, S_SETUP, S_STROBE, S_RELEASE, S_DONE
   } state_t;

   localparam logic [7:0] ALE_LAST   = 8'(ALE_CYCLES - 1);
   localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_last;
   logic        r_port;
   logic        r_wr;
   logic        r_err;
   logic [27:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_ale;
   logic        r_cs_n;
   logic        r_rd_wr;
   logic        r_oe;
   logic [31:0] r_dout;
   logic [31:0] r_rdata;

   logic        w_idle;
   logic        w_gnt0;
   logic        w_gnt1;
   logic [7:0]  w_cnt_inc;

   // With both requesting, the port that did not win last time gets the grant.
   assign w_idle    = (r_state == S_IDLE);
   assign w_gnt1    = i_req1_valid & (~i_req0_valid | ~r_last);
   assign w_gnt0    = i_req0_valid & ~w_gnt1;
   assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

   assign o_req0_ready  = w_idle & w_gnt0;
   assign o_req1_ready  = w_idle & w_gnt1;
   assign o_req0_done   = (r_state == S_DONE) & ~r_port;
   assign o_req1_done   = (r_state == S_DONE) &  r_port;
   assign o_rsp_err     = (r_state == S_DONE) &  r_err;
   assign o_rsp_rdata   = r_rdata;
   assign o_busy        = ~w_idle;
   assign o_lb_ale      = r_ale;
   assign o_lb_cs_n     = r_cs_n;
   assign o_lb_rd_wr    = r_rd_wr;
   assign o_lb_data_out = r_dout;
   assign o_lb_data_oe  = r_oe;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_last  <= 1'b1;
         r_port  <= 1'b0;
         r_wr    <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_ale   <= 1'b0;
         r_cs_n  <= 1'b1;
         r_rd_wr <= 1'b1;
         r_oe    <= 1'b0;
         r_dout  <= '0;
         r_rdata <= '0;
      end else begin
         r_cnt <= w_cnt_inc;
         case (r_state)
            S_IDLE: begin
               if (w_gnt0 | w_gnt1) begin
                  r_port  <= w_gnt1;
                  r_last  <= w_gnt1;
                  r_wr    <= w_gnt1 ? i_req1_wr    : i_req0_wr;
                  r_addr  <= w_gnt1 ? i_req1_addr  : i_req0_addr;
                  r_wdata <= w_gnt1 ? i_req1_wdata : i_req0_wdata;
                  r_dout  <= {SPACE, (w_gnt1 ? i_req1_addr : i_req0_addr)};
                  r_ale   <= 1'b1;
                  r_oe    <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_ALE;
               end
            end
            S_ALE: begin
               if (r_cnt == ALE_LAST) begin
                  r_ale   <= 1'b0;
                  r_rd_wr <= ~r_wr;
                  r_state <= S_AHOLD;
               end
            end
            S_AHOLD: begin
               r_cnt   <= '0;
               r_state <= S_SETUP;
            end
            S_SETUP: begin
               if (r_cnt == SETUP_LAST) begin
                  r_cs_n  <= 1'b0;
                  r_dout  <= r_wr ? r_wdata : '0;
                  r_oe    <= r_wr;
                  r_cnt   <= '0;
                  r_state <= S_STROBE;
               end
            end
            S_STROBE: begin
               // An ack on the final allowed cycle still counts as success.
               if (!i_lb_ack_n || r_cnt == TO_LAST) begin
                  if (!i_lb_ack_n) begin
                     if (!r_wr)
                        r_rdata <= i_lb_data_in;
                  end else begin
                     r_err <= 1'b1;
                  end
                  r_cs_n  <= 1'b1;
                  r_oe    <= 1'b0;
                  r_dout  <= '0;
                  r_cnt   <= '0;
                  r_state <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (i_lb_ack_n || r_cnt == TO_LAST) begin
                  if (!i_lb_ack_n)
                     r_err <= 1'b1;
                  r_rd_wr <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_err   <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lb_master_arb.sv
// Bench for lb_master_arb: behavioural slave plus a per-transaction timing and data model.
module tb_lb_master_arb;

   localparam int         ALE   = 2;
   localparam int         SETUP = 2;
   localparam int         TO    = 255;
   localparam logic [3:0] SPACE = 4'h1;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req0_valid = 0, req0_wr = 0, req1_valid = 0, req1_wr = 0;
   logic [27:0] req0_addr = '0, req1_addr = '0;
   logic [31:0] req0_wdata = '0, req1_wdata = '0;
   logic        req0_ready, req1_ready, req0_done, req1_done, rsp_err;
   logic [31:0] rsp_rdata;
   logic        lb_ale, lb_cs_n, lb_rd_wr, lb_data_oe, busy;
   logic [31:0] lb_data_out;
   logic [31:0] lb_data_in = '0;
   logic        lb_ack_n = 1'b1;

   always #5 clk = ~clk;

   lb_master_arb #(.ALE_CYCLES(ALE), .SETUP_CYCLES(SETUP), .TIMEOUT(TO), .SPACE(SPACE)) dut (
      .clk(clk), .reset(reset),
      .i_req0_valid(req0_valid), .i_req0_wr(req0_wr), .i_req0_addr(req0_addr), .i_req0_wdata(req0_wdata),
      .i_req1_valid(req1_valid), .i_req1_wr(req1_wr), .i_req1_addr(req1_addr), .i_req1_wdata(req1_wdata),
      .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
      .o_req0_done(req0_done), .o_req1_done(req1_done),
      .o_rsp_err(rsp_err), .o_rsp_rdata(rsp_rdata),
      .o_lb_ale(lb_ale), .o_lb_cs_n(lb_cs_n), .o_lb_rd_wr(lb_rd_wr),
      .o_lb_data_out(lb_data_out), .o_lb_data_oe(lb_data_oe),
      .i_lb_data_in(lb_data_in), .i_lb_ack_n(lb_ack_n), .o_busy(busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Slave: acks s_ack_dly cycles after cs_n falls, releases s_rel_dly cycles after cs_n rises.
   int          s_ack_dly = 2;
   int          s_rel_dly = 1;
   bit          s_noack = 0;
   int          s_cnt = 0;
   int          s_rcnt = 0;
   logic [27:0] s_addr = '0;
   logic [31:0] smem [logic [27:0]];

   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         lb_ack_n = 1'b1;
         s_cnt    = 0;
         s_rcnt   = 0;
      end else begin
         lb_data_in = $urandom;
         if (lb_ale) s_addr = lb_data_out[27:0];
         if (!lb_cs_n) begin
            s_rcnt = 0;
            if (!s_noack && s_cnt >= s_ack_dly) begin
               if (lb_ack_n && !lb_rd_wr) smem[s_addr] = lb_data_out;
               lb_ack_n = 1'b0;
               if (lb_rd_wr) lb_data_in = smem.exists(s_addr) ? smem[s_addr] : 32'h0;
            end
            s_cnt++;
         end else begin
            s_cnt = 0;
            if (!lb_ack_n) begin
               if (s_rcnt >= s_rel_dly) lb_ack_n = 1'b1;
               else s_rcnt++;
            end
         end
      end
   end

   // Reference model state
   logic [31:0] ref_mem [logic [27:0]];
   logic [31:0] exp_rdata = '0;
   bit          m_last = 1'b1;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic preset(input bit port, input bit wr, input logic [27:0] addr, input logic [31:0] wd);
      if (port) begin
         req1_valid = 1; req1_wr = wr; req1_addr = addr; req1_wdata = wd;
      end else begin
         req0_valid = 1; req0_wr = wr; req0_addr = addr; req0_wdata = wd;
      end
   endtask

   task automatic txn(input bit port, input bit wr, input logic [27:0] addr, input logic [31:0] wd,
                      input bit noack);
      int c, F, R, D, cack, relhi;
      bit extra_rdy, d0, d1, derr;
      logic [31:0] drd;
      s_noack = noack;
      preset(port, wr, addr, wd);
      #1;
      c = 0;
      while (!(port ? req1_ready : req0_ready) && c < 20) begin
         tick();
         c++;
      end
      chk("accept_wait", c, 0);
      chk("other_ready", port ? req0_ready : req1_ready, 0);
      m_last = port;
      @(posedge clk);
      #1;
      if (port) req1_valid = 0; else req0_valid = 0;
      F = -1; R = -1; D = -1; cack = -1; relhi = -1;
      extra_rdy = 0; d0 = 0; d1 = 0; derr = 0; drd = '0;
      for (c = 1; c <= 600 && D < 0; c++) begin
         tick();
         if (req0_ready | req1_ready) extra_rdy = 1;
         if (c <= ALE + 1 + SETUP) begin
            chk("ale", lb_ale, c <= ALE);
            chk("addr_phase", lb_data_out, {SPACE, addr});
            chk("addr_oe", lb_data_oe, 1);
            chk("cs_pre", lb_cs_n, 1);
            chk("rdwr_pre", lb_rd_wr, (c <= ALE) ? 1'b1 : !wr);
         end
         if (!lb_cs_n) begin
            if (F < 0) F = c;
            chk("strobe_ale", lb_ale, 0);
            chk("strobe_rdwr", lb_rd_wr, !wr);
            chk("strobe_oe", lb_data_oe, wr);
            if (wr) chk("strobe_data", lb_data_out, wd);
            if (!lb_ack_n && cack < 0) cack = c;
         end else if (F >= 0) begin
            if (R < 0) R = c;
            if (lb_ack_n && relhi < 0) relhi = c;
         end
         chk("busy", busy, 1);
         if (req0_done | req1_done) begin
            D = c; d0 = req0_done; d1 = req1_done; derr = rsp_err; drd = rsp_rdata;
         end
      end
      chk("done_seen", D > 0, 1);
      chk("cs_fall_cycle", F, ALE + SETUP + 2);
      if (noack) begin
         chk("timeout_len", R - F, TO);
      end else begin
         chk("ack_delay", cack - F, s_ack_dly);
         chk("cs_rise", R, cack + 1);
      end
      chk("done_cycle", D, relhi + 1);
      chk("done_port", {d1, d0}, port ? 2'b10 : 2'b01);
      chk("rsp_err", derr, noack);
      if (!noack) begin
         if (wr) ref_mem[addr] = wd;
         else exp_rdata = ref_mem[addr];
      end
      chk("rsp_rdata", drd, exp_rdata);
      chk("no_early_grant", extra_rdy, 0);
      tick();
      chk("idle_busy", busy, 0);
      chk("done_pulse", req0_done | req1_done, 0);
      chk("idle_cs", lb_cs_n, 1);
      chk("idle_oe", lb_data_oe, 0);
      chk("idle_rdwr", lb_rd_wr, 1);
   endtask

   initial begin
      logic [27:0] atab [16];
      logic [31:0] v;
      logic [27:0] a, b;
      bit          both, w, pa, wra, wrb;
      int          n;

      for (int i = 0; i < 16; i++) begin
         atab[i] = {2'b00, 26'($urandom)};
         if (i == 4)  atab[i] = 28'h4;
         if (i == 10) atab[i] = 28'hA;
         v = $urandom;
         if (i == 4) v = 32'hDEADBEEF;
         smem[atab[i]]    = v;
         ref_mem[atab[i]] = v;
      end

      repeat (3) tick();
      chk("rst_ale", lb_ale, 0);
      chk("rst_cs", lb_cs_n, 1);
      chk("rst_rdwr", lb_rd_wr, 1);
      chk("rst_dout", lb_data_out, 0);
      chk("rst_oe", lb_data_oe, 0);
      chk("rst_ready", {req1_ready, req0_ready}, 0);
      chk("rst_done", {req1_done, req0_done}, 0);
      chk("rst_err", rsp_err, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b1;
      repeat (2) tick();

      // Directed: write, read, contention
      s_ack_dly = 2; s_rel_dly = 1;
      txn(0, 1, 28'hA, 32'h12345678, 0);
      txn(1, 0, 28'h4, 32'h0, 0);
      chk("read_deadbeef", rsp_rdata, 32'hDEADBEEF);
      preset(1, 0, 28'hA, 32'h0);
      txn(0, 1, atab[3], 32'hA5A5_0001, 0);
      txn(1, 0, 28'hA, 32'h0, 0);
      chk("read_back_write", rsp_rdata, 32'h12345678);
      txn(0, 0, atab[3], 32'h0, 0);

      // Timeouts: write and read, each followed by a normal transaction
      txn(0, 1, atab[5], 32'hCAFE_F00D, 1);
      txn(1, 0, atab[5], 32'h0, 0);
      txn(1, 0, atab[6], 32'h0, 1);
      txn(0, 0, atab[6], 32'h0, 0);

      // Reset in the middle of a strobe
      s_ack_dly = 20;
      preset(0, 1, atab[7], 32'h0BAD_0BAD);
      n = 0;
      #1;
      while (!req0_ready && n < 20) begin tick(); n++; end
      @(posedge clk);
      #1;
      req0_valid = 0;
      n = 0;
      while (lb_cs_n && n < 30) begin tick(); n++; end
      chk("rst_reach_strobe", lb_cs_n, 0);
      reset = 1'b0;
      #1;
      chk("midrst_cs", lb_cs_n, 1);
      chk("midrst_oe", lb_data_oe, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rdwr", lb_rd_wr, 1);
      chk("midrst_rdata", rsp_rdata, 0);
      exp_rdata = '0;
      m_last = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      s_ack_dly = 2;
      preset(1, 0, atab[7], 32'h0);
      txn(0, 0, atab[7], 32'h0, 0);
      txn(1, 0, atab[7], 32'h0, 0);

      // Randomized traffic, optionally with both ports requesting
      repeat (30) begin
         s_ack_dly = $urandom_range(0, 5);
         s_rel_dly = $urandom_range(0, 3);
         both = ($urandom_range(0, 2) == 0);
         pa   = 1'($urandom_range(0, 1));
         wra  = 1'($urandom_range(0, 1));
         wrb  = 1'($urandom_range(0, 1));
         a    = atab[$urandom_range(0, 15)];
         b    = atab[$urandom_range(0, 15)];
         if (both) begin
            w = !m_last;
            v = $urandom;
            preset(!w, wrb, b, v);
            txn(w, wra, a, $urandom, 0);
            txn(!w, wrb, b, v, 0);
         end else begin
            txn(pa, wra, a, $urandom, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
